uart_rx_cdc_bridge: RTL and testbench
=====================================

Name: uart_rx_cdc_bridge

Overview:
- Receiver end of the 8N1 UART link, i.e. the reader for the serial stream our designs emit on uart_tx.
- Deserialises bytes from an external UART line and buffers them in a small FIFO.
- Presents the bytes on a valid/ready stream that drives usb_serial_top's send_data/send_valid.
- Honours send_ready (unlike the loopback top), so host-bound bytes are never lost downstream of the FIFO.

Parameters:
- CLK_DIV, 521, clk cycles per UART bit (60 MHz / 115200); legal range 16..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  input  1  single system clock (60 MHz domain).
- rstn  input  1  reset, asynchronous, active-low.
- uart_rx  input  1  asynchronous serial line; idle = 1.
- send_data  output  8  FIFO head byte.
- send_valid  output  1  FIFO not empty.
- send_ready  input  1  consumer accepts send_data this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overflow  output  1  one-cycle pulse: completed byte dropped because FIFO full.
- fifo_level  output  FIFO_AW+1  current occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rstn.
- Reset values:
  - send_valid=0, send_data=0, frame_err=0, overflow=0, fifo_level=0.
  - FSM in IDLE, synchroniser flops=1.
- Input path: uart_rx passes through a 2-flop synchroniser (reset to 1). The FSM uses only the synchronised value rx_s.
- FSM states IDLE, START, DATA, STOP (PARITY inserted when macro enabled):
  - IDLE: rx_s==0 -> START, bit counter cnt=0.
  - START: at cnt==CLK_DIV/2-1, resample. If rx_s==1 (glitch) -> IDLE with no error; else -> DATA, cnt=0, bit index=0.
  - DATA: at cnt==CLK_DIV-1, shift rx_s into bit[idx] (LSB first), cnt=0. After idx 7 -> STOP.
  - STOP: at cnt==CLK_DIV-1, sample. If 1, the byte becomes a push request; if 0, frame_err pulses and the byte is discarded. Either way -> IDLE the next cycle.
  - STOP returning to IDLE at mid-bit lets a back-to-back start edge be detected.
- FIFO behaviour (first-word-fall-through):
  - send_data is always the head entry; send_valid = (level!=0).
  - Pop when send_valid && send_ready.
  - A push is accepted when level<DEPTH, or when a pop occurs in the same cycle.
  - Simultaneous push and pop leaves level unchanged, including when full.
  - A push rejected while full pulses overflow for 1 cycle; the FIFO is unchanged.
  - Pointers wrap modulo DEPTH; level is tracked separately (no wasted slot).
  - send_ready while empty has no effect.
- Latency: push is registered 1 cycle after the stop-bit sample; send_valid rises the cycle after the push (empty FIFO).
- send_data must be stable while send_valid=1 && send_ready=0.
- Reset mid-frame: partial byte discarded, FIFO flushed, all outputs to reset values immediately.
- Line held low (break): frame_err once per frame; FSM re-arms only after rx_s returns to 1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7, sampled in state PARITY.
  - Extra output parity_err (1-bit pulse) fires on mismatch; the byte is discarded even if the stop bit is good.
  - Frame is 11 bit-times.
- Undefined: no PARITY state, no parity_err port; 8N1 only.

Decomposition:
- Package uart_cdc_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Default CLK_DIV/FIFO_AW constants.
  - Function half_bit(div).
- One sub-module, sync_fifo_fwft: param WIDTH, AW; push/full-aware accept, pop, level output.
- The FSM/sampler stays in the top.

Test Plan:
- Reset release then idle line for 2000 cycles -> send_valid=0, no pulses, fifo_level=0.
- Frame 0x41 at exact CLK_DIV=521 with send_ready=1 -> send_data=0x41, send_valid for exactly 1 cycle, rising ~2 cycles after the stop-bit midpoint.
- 17 back-to-back frames 0x00..0x10 with send_ready=0 (FIFO_AW=4) -> level=16, overflow pulses once on 0x10; then send_ready=1 drains 0x00..0x0F in order.
- Frame 0x5A with stop bit forced 0 -> frame_err one pulse, FIFO unchanged. A following valid 0xA5 is received correctly.
- 200-cycle low glitch on idle line -> FSM returns to IDLE, no error, no push. Also: ±3% baud skew on 0x55/0xAA -> both bytes correct.
- Assert rstn=0 mid-DATA with 3 bytes queued -> send_valid=0 and level=0 asynchronously. Next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_cdc_pkg.sv
// Shared types and defaults for the UART receive bridge.
//   rx_state_t : receiver FSM states (PARITY only reachable when
//                UART_RX_PARITY_EN is defined)
//   DEF_CLK_DIV / DEF_FIFO_AW : default bit period and FIFO address width
//   half_bit() : clk cycles from the start-bit edge to the start-bit centre
package uart_cdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEF_CLK_DIV = 521;   // 60 MHz / 115200 baud
    localparam int DEF_FIFO_AW = 4;

    function automatic int half_bit(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with a separately tracked level,
// so all 2**AW slots are usable.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   push, push_data  : write request and data; accepted when not full, or
//                      when a pop happens in the same cycle
//   pop              : consumer takes head this cycle (ignored when empty)
//   head             : current head entry, forced to 0 while empty
//   valid            : FIFO not empty
//   overflow         : one-cycle pulse when a push is rejected (full, no pop)
//   level            : current occupancy, 0..2**AW
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [1 << AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign valid    = (level != '0);
    assign full     = (level == {1'b1, {AW{1'b0}}});
    assign do_pop   = pop && valid;
    // When full, a same-cycle pop frees the slot the push writes into.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    // Head is gated so the output reads 0 while empty, including after reset.
    assign head     = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + (AW+1)'(1);
            else if (do_pop && !do_push) level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cdc_bridge.sv
// UART 8N1 receiver feeding a FWFT byte FIFO with a valid/ready output.
// Optional even parity: define UART_RX_PARITY_EN (adds PARITY state and the
// parity_err port; frame becomes 11 bit-times).
// Ports:
//   clk, rstn    : 60 MHz clock, asynchronous active-low reset
//   uart_rx      : asynchronous serial line, idle high
//   send_data    : FIFO head byte (0 while empty)
//   send_valid   : FIFO not empty
//   send_ready   : consumer accepts send_data this cycle
//   frame_err    : one-cycle pulse, stop bit sampled low
//   parity_err   : one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//   overflow     : one-cycle pulse, completed byte dropped on a full FIFO
//   fifo_level   : FIFO occupancy
module uart_rx_cdc_bridge
    import uart_cdc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int FIFO_AW = DEF_FIFO_AW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               uart_rx,
    output logic [7:0]         send_data,
    output logic               send_valid,
    input  logic               send_ready,
    output logic               frame_err,
`ifdef UART_RX_PARITY_EN
    output logic               parity_err,
`endif
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam logic [15:0] HALF_LAST = 16'(half_bit(CLK_DIV) - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);

    logic        rx_meta, rx_s, rx_prev;
    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push_n, ferr_n;
    logic        vld_p0, ferr_p0;
    logic [7:0]  data_p0;
`ifdef UART_RX_PARITY_EN
    logic        pbad, pbad_n, perr_n, perr_p0;
`endif

    // Two-flop synchroniser; rx_prev gives the falling edge that arms START,
    // so a line held low (break) cannot retrigger until it has gone high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        push_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_n  = pbad;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_n  = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    // A start bit that is high again at its centre is a glitch.
                    state_n = rx_s ? IDLE : DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state_n = PARITY;
`else
                    if (idx == 3'd7) state_n = STOP;
`endif
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    pbad_n  = rx_s ^ (^shreg);
                    perr_n  = pbad_n;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit leaves time to catch a back-to-back start.
                if (cnt == BIT_LAST) begin
                    state_n = IDLE;
                    if (!rx_s) ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else       push_n = !pbad;
`else
                    else       push_n = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: completed byte registered as a push request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            vld_p0  <= 1'b0;
            ferr_p0 <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad    <= 1'b0;
            perr_p0 <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            vld_p0  <= push_n;
            ferr_p0 <= ferr_n;
`ifdef UART_RX_PARITY_EN
            pbad    <= pbad_n;
            perr_p0 <= perr_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        if (push_n) data_p0 <= shreg;
    end

    assign frame_err = ferr_p0;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_p0;
`endif

    sync_fifo_fwft #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (vld_p0),
        .push_data (data_p0),
        .pop       (send_ready),
        .head      (send_data),
        .valid     (send_valid),
        .overflow  (overflow),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_uart_rx_cdc_bridge.sv
module tb_uart_rx_cdc_bridge;

    localparam int SLOW_DIV = 521;
    localparam int FAST_DIV = 64;
    localparam int AW       = 4;
    localparam int DEPTH    = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic rdy_a = 1'b1, rdy_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic vld_a, vld_b, ferr_a, ferr_b, ovf_a, ovf_b;
    logic [AW:0] lvl_a, lvl_b;
`ifdef UART_RX_PARITY_EN
    logic perr_a, perr_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact 115200-baud divider instance.
    uart_rx_cdc_bridge #(.CLK_DIV(SLOW_DIV), .FIFO_AW(AW)) u_slow (
        .clk(clk), .rstn(rstn), .uart_rx(rx_a),
        .send_data(data_a), .send_valid(vld_a), .send_ready(rdy_a),
        .frame_err(ferr_a),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr_a),
`endif
        .overflow(ovf_a), .fifo_level(lvl_a)
    );

    // Short divider instance for the multi-frame scenarios.
    uart_rx_cdc_bridge #(.CLK_DIV(FAST_DIV), .FIFO_AW(AW)) u_fast (
        .clk(clk), .rstn(rstn), .uart_rx(rx_b),
        .send_data(data_b), .send_valid(vld_b), .send_ready(rdy_b),
        .frame_err(ferr_b),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr_b),
`endif
        .overflow(ovf_b), .fifo_level(lvl_b)
    );

    // Monitors: record accepted bytes and pulses, and require a held head.
    logic [7:0] got_q[$];
    int b_ferr = 0, b_ovf = 0;
    int a_vld_cycles = 0, a_pulses = 0;
    longint a_first = -1;
    logic [7:0] a_data = '0;
    logic b_hold = 1'b0;
    logic [7:0] b_hold_data = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (vld_b && rdy_b) got_q.push_back(data_b);
            if (ferr_b) b_ferr++;
            if (ovf_b)  b_ovf++;
            if (b_hold) begin
                n_checks++;
                if (data_b !== b_hold_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: send_data %0h, required %0h", data_b, b_hold_data);
                end
            end
            b_hold      = vld_b && !rdy_b;
            b_hold_data = data_b;
            if (vld_a) begin
                if (a_vld_cycles == 0) a_first = cyc;
                a_vld_cycles++;
                a_data = data_a;
            end
            if (ferr_a || ovf_a) a_pulses++;
        end else begin
            b_hold = 1'b0;
        end
    end

    task automatic drive_bit(input bit fast, input logic v, input int n);
        if (fast) rx_b = v; else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit fast, input logic [7:0] b, input logic stop, input int period);
        drive_bit(fast, 1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(fast, b[i], period);
`ifdef UART_RX_PARITY_EN
        drive_bit(fast, ^b, period);
`endif
        drive_bit(fast, stop, period);
        if (!stop) drive_bit(fast, 1'b1, period);
    endtask

    task automatic drain_fast();
        rdy_b = 1'b1;
        for (int i = 0; i < 200 && lvl_b != '0; i++) @(negedge clk);
        n_checks++;
        if (lvl_b !== '0) begin n_fail++; $display("FAIL drain_timeout: level %0d, required 0", lvl_b); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_queue(input string name, input logic [7:0] exp_q[$]);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_byte%0d: got %0h, required %0h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (vld_a !== 1'b0 || vld_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b, required 00", vld_a, vld_b); end
        n_checks++; if (lvl_a !== '0 || lvl_b !== '0) begin n_fail++; $display("FAIL reset_level: got %0d/%0d, required 0", lvl_a, lvl_b); end
        n_checks++; if (data_a !== 8'h00 || data_b !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h/%0h, required 0", data_a, data_b); end
        n_checks++; if ({ferr_a, ferr_b, ovf_a, ovf_b} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b, required 0000", {ferr_a, ferr_b, ovf_a, ovf_b}); end
        rstn = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        n_checks++; if (a_vld_cycles != 0 || vld_b !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0d cycles, required 0", a_vld_cycles); end
        n_checks++; if (lvl_a !== '0 || lvl_b !== '0) begin n_fail++; $display("FAIL idle_level: got %0d/%0d, required 0", lvl_a, lvl_b); end
        n_checks++; if (a_pulses != 0 || b_ferr != 0 || b_ovf != 0) begin n_fail++; $display("FAIL idle_pulses: got %0d/%0d/%0d, required 0", a_pulses, b_ferr, b_ovf); end
    endtask

    task automatic test_single_frame();
        longint t0, mid;
        rdy_a = 1'b1;
        a_vld_cycles = 0; a_pulses = 0;
        @(posedge clk); #1;
        t0  = cyc;
        mid = t0 + 9 * SLOW_DIV + SLOW_DIV / 2;
        send_frame(1'b0, 8'h41, 1'b1, SLOW_DIV);
        repeat (20) @(posedge clk); #1;
        n_checks++; if (a_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %0h, required 41", a_data); end
        n_checks++; if (a_vld_cycles != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d cycles, required 1", a_vld_cycles); end
        n_checks++; if (a_first < mid || a_first > mid + 8) begin n_fail++; $display("FAIL single_latency: valid at %0d, required %0d..%0d", a_first, mid, mid + 8); end
        n_checks++; if (a_pulses != 0) begin n_fail++; $display("FAIL single_pulses: got %0d, required 0", a_pulses); end
    endtask

    task automatic test_glitch();
        a_vld_cycles = 0; a_pulses = 0;
        drive_bit(1'b0, 1'b0, 200);
        drive_bit(1'b0, 1'b1, 800);
        n_checks++; if (a_vld_cycles != 0 || lvl_a !== '0) begin n_fail++; $display("FAIL glitch_push: got %0d cycles level %0d, required 0", a_vld_cycles, lvl_a); end
        n_checks++; if (a_pulses != 0) begin n_fail++; $display("FAIL glitch_error: got %0d, required 0", a_pulses); end
        send_frame(1'b0, 8'h62, 1'b1, SLOW_DIV);
        repeat (10) @(posedge clk); #1;
        n_checks++; if (a_vld_cycles != 1 || a_data !== 8'h62) begin n_fail++; $display("FAIL glitch_rearm: got %0h x%0d, required 62 x1", a_data, a_vld_cycles); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp_q[$];
        int mlevel = 0, movf = 0;
        rdy_b = 1'b0; got_q.delete(); b_ovf = 0; b_ferr = 0;
        for (int v = 0; v <= 16; v++) begin
            send_frame(1'b1, 8'(v), 1'b1, FAST_DIV);
            if (mlevel < DEPTH) begin exp_q.push_back(8'(v)); mlevel++; end
            else movf++;
            if (v == 15) begin
                n_checks++; if (int'(lvl_b) != mlevel || b_ovf != 0) begin n_fail++; $display("FAIL fill_level16: got %0d ovf %0d, required %0d ovf 0", lvl_b, b_ovf, mlevel); end
            end
        end
        n_checks++; if (int'(lvl_b) != mlevel) begin n_fail++; $display("FAIL full_level: got %0d, required %0d", lvl_b, mlevel); end
        n_checks++; if (b_ovf != movf) begin n_fail++; $display("FAIL overflow_pulses: got %0d, required %0d", b_ovf, movf); end
        drain_fast();
        check_queue("drain_order", exp_q);
    endtask

    task automatic test_frame_err();
        logic [7:0] exp_q[$];
        rdy_b = 1'b0; got_q.delete(); b_ferr = 0;
        send_frame(1'b1, 8'h33, 1'b1, FAST_DIV); exp_q.push_back(8'h33);
        send_frame(1'b1, 8'h5A, 1'b0, FAST_DIV);
        n_checks++; if (b_ferr != 1) begin n_fail++; $display("FAIL frame_err_pulse: got %0d cycles, required 1", b_ferr); end
        n_checks++; if (int'(lvl_b) != exp_q.size()) begin n_fail++; $display("FAIL frame_err_fifo: level %0d, required %0d", lvl_b, exp_q.size()); end
        send_frame(1'b1, 8'hA5, 1'b1, FAST_DIV); exp_q.push_back(8'hA5);
        n_checks++; if (b_ferr != 1 || int'(lvl_b) != exp_q.size()) begin n_fail++; $display("FAIL after_err: ferr %0d level %0d, required 1 and %0d", b_ferr, lvl_b, exp_q.size()); end
        drain_fast();
        check_queue("frame_err_seq", exp_q);
    endtask

    task automatic test_break();
        logic [7:0] exp_q[$];
        rdy_b = 1'b1; got_q.delete(); b_ferr = 0;
        drive_bit(1'b1, 1'b0, FAST_DIV * 40);
        n_checks++; if (b_ferr != 1) begin n_fail++; $display("FAIL break_ferr: got %0d, required 1", b_ferr); end
        n_checks++; if (got_q.size() != 0 || lvl_b !== '0) begin n_fail++; $display("FAIL break_push: got %0d bytes, required 0", got_q.size()); end
        drive_bit(1'b1, 1'b1, FAST_DIV * 2);
        send_frame(1'b1, 8'h3C, 1'b1, FAST_DIV); exp_q.push_back(8'h3C);
        repeat (5) @(posedge clk); #1;
        check_queue("break_rearm", exp_q);
    endtask

    task automatic test_skew();
        logic [7:0] exp_q[$];
        rdy_b = 1'b1; got_q.delete(); b_ferr = 0;
        send_frame(1'b1, 8'h55, 1'b1, 66); exp_q.push_back(8'h55);
        send_frame(1'b1, 8'hAA, 1'b1, 62); exp_q.push_back(8'hAA);
        repeat (5) @(posedge clk); #1;
        check_queue("skew", exp_q);
        n_checks++; if (b_ferr != 0) begin n_fail++; $display("FAIL skew_ferr: got %0d, required 0", b_ferr); end
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] exp_q[$];
        bit done = 1'b0;
        got_q.delete(); b_ferr = 0; b_ovf = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    send_frame(1'b1, b, 1'b1, int'($urandom_range(63, 65)));
                    exp_q.push_back(b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rdy_b = 1'($urandom_range(0, 1));
                end
            end
        join
        drain_fast();
        check_queue("random", exp_q);
        n_checks++; if (b_ferr != 0 || b_ovf != 0) begin n_fail++; $display("FAIL random_pulses: ferr %0d ovf %0d, required 0", b_ferr, b_ovf); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_q[$];
        rdy_b = 1'b0; got_q.delete(); b_ferr = 0;
        for (int k = 0; k < 3; k++) send_frame(1'b1, 8'($urandom), 1'b1, FAST_DIV);
        n_checks++; if (lvl_b !== 5'd3) begin n_fail++; $display("FAIL pre_reset_level: got %0d, required 3", lvl_b); end
        drive_bit(1'b1, 1'b0, FAST_DIV);
        drive_bit(1'b1, 1'b1, FAST_DIV);
        drive_bit(1'b1, 1'b0, FAST_DIV / 2);
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (vld_b !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b, required 0", vld_b); end
        n_checks++; if (lvl_b !== '0) begin n_fail++; $display("FAIL async_reset_level: got %0d, required 0", lvl_b); end
        rx_b = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        repeat (100) @(posedge clk); #1;
        rdy_b = 1'b1; got_q.delete();
        send_frame(1'b1, 8'h7E, 1'b1, FAST_DIV); exp_q.push_back(8'h7E);
        repeat (5) @(posedge clk); #1;
        check_queue("after_reset", exp_q);
        n_checks++; if (b_ferr != 0) begin n_fail++; $display("FAIL after_reset_ferr: got %0d, required 0", b_ferr); end
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_fill_overflow();
        test_frame_err();
        test_break();
        test_skew();
        test_back_to_back_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
